// File: rtl/hilo_mult_if.sv
// Handshake and result bundle between the EX stage and the HI/LO multiply sequencer.
// The master drives start/read requests; the slave (sequencer) returns HI/LO and status.
interface hilo_mult_if #(
    parameter int WIDTH = 32
);
    logic             enhilo_EX;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       regsel_EX;
    logic [WIDTH-1:0] hilo_rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall_FETCH;

    modport master (
        output enhilo_EX, is_signed, op_a, op_b, regsel_EX,
        input  hilo_rdata, hi, lo, busy, done, stall_FETCH
    );

    modport slave (
        input  enhilo_EX, is_signed, op_a, op_b, regsel_EX,
        output hilo_rdata, hi, lo, busy, done, stall_FETCH
    );
endinterface

// File: rtl/hilo_mult_sequencer.sv
// Iterative shift-add multiplier owning HI/LO; serves mfhi/mflo and stalls fetch on hazards.
// Optional macro HILO_EARLY_TERM_EN: finish early once the remaining multiplier bits are zero.
module hilo_mult_sequencer #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    hilo_mult_if.slave mif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic               wr_p0;
    logic               done_p1;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               run_last;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        logic signed [WIDTH-1:0] sv;
        logic [WIDTH-1:0]        m;
        sv = v;
        // -2^(W-1) maps to 2^(W-1), which is still representable unsigned
        if (sgn && sv[WIDTH-1])
            m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        else
            m = v;
        return m;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic n);
        logic [2*WIDTH-1:0] r;
        if (n)
            r = ~p + {{(2*WIDTH-1){1'b0}}, 1'b1};
        else
            r = p;
        return r;
    endfunction

`ifdef HILO_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] prod_step;
    logic [CNT_W-1:0]   skip;

    always_comb begin
        sum       = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_step = {sum, mplier[WIDTH-1:1]};
        skip      = CNT_W'(WIDTH - 1) - cnt;
        // nothing left to add: slide the product into place in one step
        if (rem[WIDTH-1:1] == '0) begin
            prod_nxt = prod_step >> skip;
            run_last = 1'b1;
        end else begin
            prod_nxt = prod_step;
            run_last = (cnt == CNT_W'(WIDTH - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rem <= '0;
        else if (state == IDLE && mif.enhilo_EX)
            rem <= magnitude(mif.op_b, mif.is_signed);
        else if (state == RUN)
            rem <= rem >> 1;
    end
`else
    always_comb begin
        sum      = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_nxt = {sum, mplier[WIDTH-1:1]};
        run_last = (cnt == CNT_W'(WIDTH - 1));
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mif.enhilo_EX) state_nxt = RUN;
            RUN:     if (run_last) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0: operand capture / iteration / HI-LO write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc_hi <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mif.enhilo_EX) begin
                        mcand  <= magnitude(mif.op_a, mif.is_signed);
                        mplier <= magnitude(mif.op_b, mif.is_signed);
                        neg    <= mif.is_signed & (mif.op_a[WIDTH-1] ^ mif.op_b[WIDTH-1]);
                        acc_hi <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    {acc_hi, mplier} <= prod_nxt;
                    cnt              <= cnt + CNT_W'(1);
                end
                FIX: begin
                    {hi_r, lo_r} <= apply_sign({acc_hi, mplier}, neg);
                end
                default: ;
            endcase
        end
    end

    // p1: done trails the HI/LO write by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_p0   <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            wr_p0   <= (state == FIX);
            done_p1 <= wr_p0;
        end
    end

    always_comb begin
        case (mif.regsel_EX)
            2'd1:    mif.hilo_rdata = hi_r;
            2'd2:    mif.hilo_rdata = lo_r;
            default: mif.hilo_rdata = '0;
        endcase
    end

    assign mif.hi          = hi_r;
    assign mif.lo          = lo_r;
    assign mif.busy        = (state != IDLE);
    assign mif.done        = done_p1;
    assign mif.stall_FETCH = (state != IDLE) &&
                             (mif.enhilo_EX || mif.regsel_EX == 2'd1 || mif.regsel_EX == 2'd2);

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for hilo_mult_sequencer (default build, fixed latency).
module tb_hilo_mult_sequencer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hilo_mult_if #(.WIDTH(W)) mif ();

    hilo_mult_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start and return 1ns after the accepting edge (E0).
    task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        mif.is_signed = sgn;
        mif.op_a      = a;
        mif.op_b      = b;
        mif.enhilo_EX = 1'b1;
        step();
        mif.enhilo_EX = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        mif.regsel_EX = 2'd1;
        mif.enhilo_EX = 1'b1;
        #1;
        n_total++;
        if (mif.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", mif.busy);
        else n_pass++;
        n_total++;
        if (mif.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", mif.done);
        else n_pass++;
        n_total++;
        if (mif.hi !== 32'h0 || mif.lo !== 32'h0)
            $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", mif.hi, mif.lo);
        else n_pass++;
        n_total++;
        if (mif.stall_FETCH !== 1'b0) $display("FAIL reset_stall: got %b expected 0", mif.stall_FETCH);
        else n_pass++;
        n_total++;
        if (mif.hilo_rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", mif.hilo_rdata);
        else n_pass++;
        mif.regsel_EX = 2'd0;
        mif.enhilo_EX = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        step();
    endtask

    task automatic test_multu_max();
        int busy_fall;
        int done_at;
        int done_cnt;
        busy_fall = -1;
        done_at   = -1;
        done_cnt  = 0;
        start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_total++;
        if (mif.busy !== 1'b1) $display("FAIL max_busy_start: got %b expected 1", mif.busy);
        else n_pass++;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (!mif.busy && busy_fall < 0) busy_fall = k;
            if (mif.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        n_total++;
        if (busy_fall !== 33) $display("FAIL max_busy_fall: got %0d expected 33", busy_fall);
        else n_pass++;
        n_total++;
        if (done_at !== 34) $display("FAIL max_done_latency: got %0d expected 34", done_at);
        else n_pass++;
        n_total++;
        if (done_cnt !== 1) $display("FAIL max_done_width: got %0d expected 1", done_cnt);
        else n_pass++;
        n_total++;
        if (mif.hi !== 32'hFFFF_FFFE || mif.lo !== 32'h0000_0001)
            $display("FAIL max_product: got hi=%h lo=%h expected FFFFFFFE/00000001", mif.hi, mif.lo);
        else n_pass++;
    endtask

    task automatic test_products();
        logic          ts [6];
        logic [W-1:0]  ta [6];
        logic [W-1:0]  tb [6];
        logic [W-1:0]  th [6];
        logic [W-1:0]  tl [6];
        ts = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ta = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF};
        tb = '{32'h0000_0003, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        th = '{32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        tl = '{32'hFFFF_FFFA, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFDD, 32'h0000_0001};
        for (int i = 0; i < 6; i++) begin
            start_op(ts[i], ta[i], tb[i]);
            repeat (36) step();
            n_total++;
            if (mif.hi !== th[i] || mif.lo !== tl[i])
                $display("FAIL product_%0d: got hi=%h lo=%h expected %h/%h", i, mif.hi, mif.lo, th[i], tl[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mfhi_mflo();
        start_op(1'b1, 32'hFFFF_FFFE, 32'h0000_0003);
        repeat (36) step();
        mif.regsel_EX = 2'd2;
        #1;
        n_total++;
        if (mif.hilo_rdata !== 32'hFFFF_FFFA) $display("FAIL mflo: got %h expected FFFFFFFA", mif.hilo_rdata);
        else n_pass++;
        mif.regsel_EX = 2'd1;
        #1;
        n_total++;
        if (mif.hilo_rdata !== 32'hFFFF_FFFF) $display("FAIL mfhi: got %h expected FFFFFFFF", mif.hilo_rdata);
        else n_pass++;
        mif.regsel_EX = 2'd3;
        #1;
        n_total++;
        if (mif.hilo_rdata !== 32'h0) $display("FAIL no_read: got %h expected 0", mif.hilo_rdata);
        else n_pass++;
        mif.regsel_EX = 2'd0;
        step();
    endtask

    task automatic test_read_stall();
        int fall;
        int stall_cnt;
        logic [W-1:0] rd;
        logic st;
        fall      = -1;
        stall_cnt = 0;
        rd        = '0;
        st        = 1'b1;
        start_op(1'b0, 32'h1234_5678, 32'h0000_0010);
        mif.regsel_EX = 2'd1;
        #1;
        n_total++;
        if (mif.stall_FETCH !== 1'b1) $display("FAIL read_stall_first: got %b expected 1", mif.stall_FETCH);
        else n_pass++;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (mif.busy) begin
                if (mif.stall_FETCH) stall_cnt++;
            end else if (fall < 0) begin
                fall = k;
                rd   = mif.hilo_rdata;
                st   = mif.stall_FETCH;
            end
        end
        n_total++;
        if (fall !== 33 || stall_cnt !== 32)
            $display("FAIL read_stall_span: got fall=%0d stalls=%0d expected 33/32", fall, stall_cnt);
        else n_pass++;
        n_total++;
        if (st !== 1'b0 || rd !== 32'h0000_0001)
            $display("FAIL read_after_busy: got stall=%b rdata=%h expected 0/00000001", st, rd);
        else n_pass++;
        mif.regsel_EX = 2'd0;
    endtask

    task automatic test_back_to_back();
        int stall_cnt;
        int fall_b;
        logic busy33, stall33, busy34;
        logic [W-1:0] hi33, lo33;
        stall_cnt = 0;
        fall_b    = -1;
        busy33 = 1'b1; stall33 = 1'b1; busy34 = 1'b0;
        hi33 = '1; lo33 = '1;
        start_op(1'b0, 32'd3, 32'd5);
        mif.op_a      = 32'd6;
        mif.op_b      = 32'd7;
        mif.enhilo_EX = 1'b1;
        for (int k = 1; k <= 75; k++) begin
            step();
            if (k <= 32 && mif.stall_FETCH) stall_cnt++;
            if (k == 33) begin
                busy33  = mif.busy;
                stall33 = mif.stall_FETCH;
                hi33    = mif.hi;
                lo33    = mif.lo;
            end
            if (k == 34) begin
                busy34        = mif.busy;
                mif.enhilo_EX = 1'b0;
            end
            if (k > 34 && !mif.busy && fall_b < 0) fall_b = k;
        end
        n_total++;
        if (stall_cnt !== 32) $display("FAIL b2b_stall_cycles: got %0d expected 32", stall_cnt);
        else n_pass++;
        n_total++;
        if (busy33 !== 1'b0 || stall33 !== 1'b0)
            $display("FAIL b2b_idle_gap: got busy=%b stall=%b expected 0/0", busy33, stall33);
        else n_pass++;
        n_total++;
        if (hi33 !== 32'd0 || lo33 !== 32'd15)
            $display("FAIL b2b_first_result: got hi=%h lo=%h expected 0/0000000f", hi33, lo33);
        else n_pass++;
        n_total++;
        if (busy34 !== 1'b1) $display("FAIL b2b_second_accept: got busy=%b expected 1", busy34);
        else n_pass++;
        n_total++;
        if (fall_b !== 67 || mif.hi !== 32'd0 || mif.lo !== 32'd42)
            $display("FAIL b2b_second_result: got fall=%0d hi=%h lo=%h expected 67/0/0000002a", fall_b, mif.hi, mif.lo);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        int busy_cnt;
        done_cnt = 0;
        busy_cnt = 0;
        start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) step();
        rst = 1'b1;
        #1;
        n_total++;
        if (mif.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", mif.busy);
        else n_pass++;
        n_total++;
        if (mif.hi !== 32'h0 || mif.lo !== 32'h0)
            $display("FAIL midrst_hilo: got hi=%h lo=%h expected 0/0", mif.hi, mif.lo);
        else n_pass++;
        step();
        rst = 1'b0;
        repeat (40) begin
            step();
            if (mif.done) done_cnt++;
            if (mif.busy) busy_cnt++;
        end
        n_total++;
        if (done_cnt !== 0 || busy_cnt !== 0)
            $display("FAIL midrst_quiet: got done=%0d busy=%0d expected 0/0", done_cnt, busy_cnt);
        else n_pass++;
        done_cnt = 0;
        start_op(1'b0, 32'd2, 32'd3);
        repeat (36) begin
            step();
            if (mif.done) done_cnt++;
        end
        n_total++;
        if (done_cnt !== 1 || mif.hi !== 32'd0 || mif.lo !== 32'd6)
            $display("FAIL midrst_restart: got done=%0d hi=%h lo=%h expected 1/0/00000006", done_cnt, mif.hi, mif.lo);
        else n_pass++;
    endtask

    initial begin
        rst           = 1'b1;
        mif.enhilo_EX = 1'b0;
        mif.is_signed = 1'b0;
        mif.op_a      = '0;
        mif.op_b      = '0;
        mif.regsel_EX = 2'd0;
        test_reset();
        test_multu_max();
        test_products();
        test_mfhi_mflo();
        test_read_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
